// File: rtl/decod_pipe.sv
// Pipelined RV32 field decoder: combinational decode of all six base formats
// into a 2-entry valid/ready FIFO, with decode and illegal event counters.
module decod_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_instr,
    input  logic [XLEN-1:0]  i_pc_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_pc_out,
    output logic [6:0]       o_opcode,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [2:0]       o_funct3,
    output logic [6:0]       o_funct7,
    output logic [XLEN-1:0]  o_immediate,
    output logic [2:0]       o_tipo,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_decoded_count,
    output logic [CNT_W-1:0] o_illegal_count
);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtIll = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      tipo;
        logic            illegal;
    } entry_t;

    fmt_e        w_fmt;
    logic [31:0] w_imm32;
    entry_t      w_dec;
    entry_t      w_head;
    logic        w_push;
    logic        w_pop;

    entry_t          r_mem [2];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;
    logic [CNT_W-1:0] r_decoded_count;
    logic [CNT_W-1:0] r_illegal_count;

    always_comb begin
        w_fmt = FmtIll;
        case (i_instr[6:0])
            7'b0110011:                                     w_fmt = FmtR;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FmtI;
            7'b0100011:                                     w_fmt = FmtS;
            7'b1100011:                                     w_fmt = FmtB;
            7'b0110111, 7'b0010111:                         w_fmt = FmtU;
            7'b1101111:                                     w_fmt = FmtJ;
            default:                                        w_fmt = FmtIll;
        endcase
    end

    // Unused fields stay zero so every stored entry is fully deterministic.
    always_comb begin
        w_imm32        = '0;
        w_dec          = '0;
        w_dec.pc       = i_pc_in;
        w_dec.opcode   = i_instr[6:0];
        w_dec.tipo     = w_fmt;
        case (w_fmt)
            FmtR: begin
                w_dec.rd     = i_instr[11:7];
                w_dec.rs1    = i_instr[19:15];
                w_dec.rs2    = i_instr[24:20];
                w_dec.funct3 = i_instr[14:12];
                w_dec.funct7 = i_instr[31:25];
            end
            FmtI: begin
                w_dec.rd     = i_instr[11:7];
                w_dec.rs1    = i_instr[19:15];
                w_dec.funct3 = i_instr[14:12];
                w_imm32      = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            FmtS: begin
                w_dec.rs1    = i_instr[19:15];
                w_dec.rs2    = i_instr[24:20];
                w_dec.funct3 = i_instr[14:12];
                w_imm32      = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            FmtB: begin
                w_dec.rs1    = i_instr[19:15];
                w_dec.rs2    = i_instr[24:20];
                w_dec.funct3 = i_instr[14:12];
                w_imm32      = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            end
            FmtU: begin
                w_dec.rd     = i_instr[11:7];
                w_imm32      = {i_instr[31:12], 12'b0};
            end
            FmtJ: begin
                w_dec.rd     = i_instr[11:7];
                w_imm32      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.imm = XLEN'($signed(w_imm32));
    end

    assign o_in_ready  = i_reset_n && (r_count < 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_mem[0]        <= '0;
            r_mem[1]        <= '0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_count         <= 2'd0;
            r_decoded_count <= '0;
            r_illegal_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_dec;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr          <= ~r_rptr;
                r_decoded_count <= r_decoded_count + CNT_W'(1);
                if (w_head.illegal && (r_illegal_count != '1)) begin
                    r_illegal_count <= r_illegal_count + CNT_W'(1);
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_pc_out        = w_head.pc;
    assign o_opcode        = w_head.opcode;
    assign o_rd            = w_head.rd;
    assign o_rs1           = w_head.rs1;
    assign o_rs2           = w_head.rs2;
    assign o_funct3        = w_head.funct3;
    assign o_funct7        = w_head.funct7;
    assign o_immediate     = w_head.imm;
    assign o_tipo          = w_head.tipo;
    assign o_illegal       = w_head.illegal;
    assign o_decoded_count = r_decoded_count;
    assign o_illegal_count = r_illegal_count;

endmodule

// File: tb/tb_decod_pipe.sv
// Directed bench for decod_pipe: one 32-bit instance with 16-bit counters and
// one 64-bit instance with 2-bit counters, sharing a clock.
module tb_decod_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: XLEN=32, CNT_W=16
    logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_instr, a_pc_in, a_pc_out, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_tipo;
    logic        a_illegal;
    logic [15:0] a_dcnt, a_icnt;

    // Instance B: XLEN=64, CNT_W=2
    logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_instr;
    logic [63:0] b_pc_in, b_pc_out, b_imm;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_tipo;
    logic        b_illegal;
    logic [1:0]  b_dcnt, b_icnt;

    decod_pipe #(.XLEN(32), .CNT_W(16)) u_dut_a (
        .i_clock(clk), .i_reset_n(a_rst_n), .i_in_valid(a_in_valid),
        .o_in_ready(a_in_ready), .i_instr(a_instr), .i_pc_in(a_pc_in),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_pc_out(a_pc_out),
        .o_opcode(a_opcode), .o_rd(a_rd), .o_rs1(a_rs1), .o_rs2(a_rs2),
        .o_funct3(a_funct3), .o_funct7(a_funct7), .o_immediate(a_imm),
        .o_tipo(a_tipo), .o_illegal(a_illegal), .o_decoded_count(a_dcnt),
        .o_illegal_count(a_icnt)
    );

    decod_pipe #(.XLEN(64), .CNT_W(2)) u_dut_b (
        .i_clock(clk), .i_reset_n(b_rst_n), .i_in_valid(b_in_valid),
        .o_in_ready(b_in_ready), .i_instr(b_instr), .i_pc_in(b_pc_in),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_pc_out(b_pc_out),
        .o_opcode(b_opcode), .o_rd(b_rd), .o_rs1(b_rs1), .o_rs2(b_rs2),
        .o_funct3(b_funct3), .o_funct7(b_funct7), .o_immediate(b_imm),
        .o_tipo(b_tipo), .o_illegal(b_illegal), .o_decoded_count(b_dcnt),
        .o_illegal_count(b_icnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_instr = '0; a_pc_in = '0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_instr = '0; b_pc_in = '0;
        step();
        step();
        chk("a_rst_in_ready", a_in_ready, 0);
        chk("a_rst_out_valid", a_out_valid, 0);
        chk("a_rst_dcnt", a_dcnt, 0);
        chk("a_rst_icnt", a_icnt, 0);
        chk("a_rst_imm", a_imm, 0);
        chk("a_rst_tipo", a_tipo, 0);
        chk("b_rst_in_ready", b_in_ready, 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();
        chk("a_rel_in_ready", a_in_ready, 1);
        chk("b_rel_in_ready", b_in_ready, 1);

        // R: add x3,x1,x2
        a_in_valid = 1'b1; a_instr = 32'h002081B3; a_pc_in = 32'h100; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("r_out_valid", a_out_valid, 1);
        chk("r_opcode", a_opcode, 7'h33);
        chk("r_rd", a_rd, 3);
        chk("r_rs1", a_rs1, 1);
        chk("r_rs2", a_rs2, 2);
        chk("r_funct3", a_funct3, 0);
        chk("r_funct7", a_funct7, 0);
        chk("r_tipo", a_tipo, 0);
        chk("r_imm", a_imm, 0);
        chk("r_pc", a_pc_out, 32'h100);
        step();
        chk("r_dcnt", a_dcnt, 1);
        chk("r_empty", a_out_valid, 0);

        // I then U, back to back with simultaneous push/pop
        a_in_valid = 1'b1; a_instr = 32'hFFF00293; a_pc_in = 32'h104;
        step();
        chk("i_tipo", a_tipo, 1);
        chk("i_rd", a_rd, 5);
        chk("i_rs1", a_rs1, 0);
        chk("i_rs2", a_rs2, 0);
        chk("i_imm", a_imm, 32'hFFFFFFFF);
        a_instr = 32'h123453B7; a_pc_in = 32'h108;
        step();
        a_in_valid = 1'b0;
        chk("u_valid", a_out_valid, 1);
        chk("u_tipo", a_tipo, 4);
        chk("u_rd", a_rd, 7);
        chk("u_rs1", a_rs1, 0);
        chk("u_imm", a_imm, 32'h12345000);
        chk("u_pc", a_pc_out, 32'h108);
        step();
        chk("iu_dcnt", a_dcnt, 3);

        // Illegal: all zero word, then opcode with low bits != 11
        a_in_valid = 1'b1; a_instr = 32'h00000000;
        step();
        a_in_valid = 1'b0;
        chk("ill0_tipo", a_tipo, 7);
        chk("ill0_flag", a_illegal, 1);
        chk("ill0_rd", a_rd, 0);
        chk("ill0_rs1", a_rs1, 0);
        chk("ill0_rs2", a_rs2, 0);
        step();
        chk("ill0_icnt", a_icnt, 1);
        chk("ill0_dcnt", a_dcnt, 4);
        a_in_valid = 1'b1; a_instr = 32'h00208031;
        step();
        a_in_valid = 1'b0;
        chk("ill1_tipo", a_tipo, 7);
        chk("ill1_opcode", a_opcode, 7'h31);
        chk("ill1_rs2", a_rs2, 0);
        chk("ill1_imm", a_imm, 0);
        step();
        chk("ill1_icnt", a_icnt, 2);

        // Backpressure: three offers against a stalled consumer
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_instr = 32'h00100093; a_pc_in = 32'h200;
        step();
        chk("bp_rdy1", a_in_ready, 1);
        a_instr = 32'h00200113; a_pc_in = 32'h204;
        step();
        chk("bp_rdy2", a_in_ready, 0);
        chk("bp_head_rd", a_rd, 1);
        a_instr = 32'h00300193; a_pc_in = 32'h208;
        step();
        chk("bp_hold_rdy", a_in_ready, 0);
        chk("bp_hold_rd", a_rd, 1);
        chk("bp_hold_imm", a_imm, 1);
        chk("bp_hold_pc", a_pc_out, 32'h200);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("bp_pop_rdy", a_in_ready, 1);
        chk("bp_pop_rd", a_rd, 2);
        step();
        a_in_valid = 1'b0;
        chk("bp_full_again", a_in_ready, 0);
        chk("bp_still2", a_rd, 2);
        a_out_ready = 1'b1;
        step();
        chk("bp_third_rd", a_rd, 3);
        chk("bp_third_imm", a_imm, 3);
        step();
        chk("bp_drained", a_out_valid, 0);
        chk("bp_dcnt", a_dcnt, 8);

        // Reset with two buffered entries
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_instr = 32'h00100093;
        step();
        a_instr = 32'h00200113;
        step();
        a_in_valid = 1'b0;
        chk("mr_full", a_in_ready, 0);
        a_rst_n = 1'b0;
        #1;
        chk("mr_rdy_low", a_in_ready, 0);
        step();
        chk("mr_out_valid", a_out_valid, 0);
        chk("mr_dcnt", a_dcnt, 0);
        chk("mr_icnt", a_icnt, 0);
        chk("mr_rdy_in_rst", a_in_ready, 0);
        a_rst_n = 1'b1;
        a_out_ready = 1'b1;
        step();
        chk("mr_rdy_after", a_in_ready, 1);
        chk("mr_no_stale", a_out_valid, 0);
        chk("mr_dcnt_after", a_dcnt, 0);

        // XLEN=64: B with negative offset, U with bit 31 set
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_instr = 32'hFE000EE3; b_pc_in = 64'h80;
        step();
        chk("b_tipo", b_tipo, 3);
        chk("b_rd", b_rd, 0);
        chk("b_funct3", b_funct3, 0);
        chk("b_imm", b_imm, 64'hFFFFFFFFFFFFFFFC);
        b_instr = 32'h800000B7;
        step();
        b_in_valid = 1'b0;
        chk("u64_tipo", b_tipo, 4);
        chk("u64_rd", b_rd, 1);
        chk("u64_imm", b_imm, 64'hFFFFFFFF80000000);
        step();
        chk("b64_dcnt", b_dcnt, 2);

        // CNT_W=2: five illegal pops from reset
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        b_in_valid = 1'b1; b_instr = 32'h00000000;
        for (int i = 0; i < 5; i++) step();
        b_in_valid = 1'b0;
        step();
        chk("sat_icnt", b_icnt, 3);
        chk("wrap_dcnt", b_dcnt, 1);
        chk("sat_empty", b_out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decod_pipe.md
Name: decod_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle RV32 field decoder.
- Decodes all six RISC-V base formats (R, I, S, B, U, J).
- Assembles and sign-extends the immediate to XLEN and flags illegal opcodes.
- Sits between fetch and register-read behind a 2-entry valid/ready skid buffer, and keeps decode/illegal event counters.

Parameters:
- XLEN, 32, datapath width; immediate and pc width (32 or 64).
- CNT_W, 16, width of the decoded_count and illegal_count counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  instr/pc_in are valid.
- in_ready  out  1  block can accept an instruction this cycle.
- instr  in  32  raw instruction word.
- pc_in  in  XLEN  pc of instr.
- out_valid  out  1  decoded entry is present on the outputs.
- out_ready  in  1  consumer accepts the entry this cycle.
- pc_out  out  XLEN  pc of the presented entry.
- opcode  out  7  instr[6:0].
- rd  out  5  destination register.
- rs1  out  5  source register 1.
- rs2  out  5  source register 2.
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- immediate  out  XLEN  assembled, sign-extended immediate.
- tipo  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.
- illegal  out  1  opcode not recognised.
- decoded_count  out  CNT_W  entries popped; wraps.
- illegal_count  out  CNT_W  illegal entries popped; saturates at all-ones.

Behaviour:
- Reset (reset_n low at a rising edge):
  - Buffer count=0; out_valid=0.
  - All data outputs and both counters = 0.
  - in_ready=0 while reset_n is low; in_ready=1 in the first cycle after release.
  - Reset mid-operation discards buffered entries with no pop and no count update.
- Opcode map:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Anything else, including instr[1:0]≠11 → tipo=7, illegal=1, immediate=0.
- Immediate construction, then sign-extended from its top bit to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; sign-extended from bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: immediate = 0.
- Field zeroing, so every output is deterministic:
  - rd=0 for S/B/ILLEGAL.
  - rs1=0 for U/J/ILLEGAL.
  - rs2=0 for I/U/J/ILLEGAL.
  - funct7=0 unless R.
  - funct3=0 for U/J/ILLEGAL.
  - opcode is always the raw instr[6:0].
- Decode is combinational on instr and is stored into the buffer entry at push.
- Buffer:
  - 2-entry FIFO.
  - in_ready = (count<2); depends on count only, never on out_ready.
  - Push on in_valid&&in_ready; pop on out_valid&&out_ready.
  - out_valid = (count>0); outputs always show the head entry.
- Latency: an instruction pushed at edge N is visible with out_valid=1 in cycle N+1 when the buffer was empty.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
  - With count=2, no push is possible even if a pop occurs that cycle; in_ready rises the cycle after the pop.
- Hold stability: head-entry outputs do not change while out_valid && !out_ready.
- Counters update on pop only:
  - decoded_count += 1, wrapping at 2^CNT_W.
  - illegal_count += 1 if the popped entry is illegal, holding at all-ones once saturated.

Test Plan:
- R decode, XLEN=32: push 0x002081B3 (add x3,x1,x2) with out_ready=1 → next cycle out_valid=1, opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, tipo=0, immediate=0; decoded_count=1 after the pop.
- I and U sign handling: push 0xFFF00293 then 0x123453B7.
  - First → tipo=1, rd=5, rs1=0, immediate=0xFFFFFFFF.
  - Second → tipo=4, rd=7, rs1=0, immediate=0x12345000.
- B and XLEN=64: push 0xFE000EE3 (beq x0,x0,-4) → tipo=3, rd=0, immediate=0xFFFFFFFFFFFFFFFC, funct3=0.
- Illegal: push 0x00000000 → tipo=7, illegal=1, all register fields 0; illegal_count=1 after the pop.
  - With CNT_W=2, five illegal pops → illegal_count holds at 3 and decoded_count wraps to 1.
- Backpressure: out_ready=0, offer 3 instructions back to back.
  - First two are accepted; in_ready=0 from the cycle after the second push; outputs hold the first entry.
  - Raise out_ready for one cycle → first entry popped, in_ready=1 next cycle, third instruction accepted; order is 1, 2, 3.
- Reset mid-operation: buffer holding 2 entries, drive reset_n=0 for one edge → out_valid=0, counters=0, in_ready=0 during reset and 1 the following cycle; no stale entry reappears.
